mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single data-memory port between the instruction-fetch unit (IFU) and the load/store path (LSU).
- Uses round-robin arbitration when both request in the same cycle.
- Keeps exactly one transaction outstanding, sequenced by a 3-state FSM.
- Registers each response and routes it back to the owning requester; a response timeout produces a bus-error response instead of a hang.

Parameters:
- TIMEOUT, 255: WAIT-state cycles allowed before a bus-error response is forced; 0 disables the timeout.
- CNT_W, 8: timeout counter width. Must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-high
- ifu_req_valid  input  1  fetch request
- ifu_req_ready  output  1  fetch request accepted this cycle
- ifu_addr  input  32  fetch address
- ifu_resp_valid  output  1  one-cycle fetch response pulse
- ifu_rdata  output  32  fetch data
- lsu_req_valid  input  1  load/store request
- lsu_req_ready  output  1  load/store request accepted this cycle
- lsu_addr  input  32  load/store address
- lsu_wen  input  1  1 = store, 0 = load
- lsu_wdata  input  32  store data
- lsu_funct3  input  3  access size/sign (RV32 funct3 encoding)
- lsu_resp_valid  output  1  one-cycle load/store response pulse
- lsu_rdata  output  32  load data
- mem_req_valid  output  1  request to memory
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  32  registered address
- mem_wen  output  1  registered write enable
- mem_wdata  output  32  registered write data
- mem_funct3  output  3  registered size
- mem_resp_valid  input  1  memory response
- mem_rdata  input  32  memory read data
- busy  output  1  FSM not in IDLE
- bus_err  output  1  sticky timeout flag
- err_addr  output  32  address of the first timed-out access

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE.
  - All outputs 0, including all registered request fields, both rdata registers, bus_err and err_addr.
  - last_owner=IFU, so the LSU wins the first tie.
- FSM states: IDLE, REQ, WAIT.
- IDLE, arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant the one that is not last_owner.
  - Ready is combinational: the granted requester's *_req_ready = 1 in IDLE only. The other requester's ready = 0.
  - Handshake (valid&ready) does all of the following:
    - Latches addr, wen, wdata and funct3 into the mem_* registers.
    - Records owner and sets last_owner=owner.
    - Moves to REQ.
  - IFU request is issued as wen=0, funct3=3'b010, wdata=0.
- REQ:
  - mem_req_valid=1; mem_* fields are held stable.
  - On mem_req_ready=1, go to WAIT and clear the counter.
  - mem_resp_valid is ignored in REQ.
- WAIT:
  - On mem_resp_valid=1:
    - Capture mem_rdata into the owner's rdata register.
    - Pulse the owner's resp_valid in the next cycle.
    - Go to IDLE.
  - Otherwise, if TIMEOUT!=0 and cnt==TIMEOUT-1:
    - Force the response with rdata=0 and pulse the owner's resp_valid next cycle.
    - Set bus_err; capture mem_addr into err_addr only if bus_err was 0.
    - Go to IDLE.
  - Otherwise cnt increments.
- Latency:
  - Request handshake at cycle T → mem_req_valid rises at T+1.
  - Memory response at cycle R → owner's resp_valid at R+1, when the FSM is already in IDLE.
  - A new request can therefore be accepted in the same cycle as the resp_valid pulse.
- Response side:
  - Stores also receive a resp_valid pulse (write acknowledge); lsu_rdata then holds mem_rdata as sampled.
  - rdata registers hold their value until the next response for that owner.
  - resp_valid is exactly one cycle wide.
- Boundary conditions:
  - Requester valid deasserting while in REQ/WAIT has no effect; the transaction completes.
  - mem_resp_valid in IDLE is ignored.
  - mem_resp_valid on the timeout cycle: the response wins, with no error.
  - Asynchronous reset mid-transaction aborts it: FSM returns to IDLE, no resp_valid is issued, bus_err is cleared.
  - bus_err clears only on reset.
- Width rules:
  - The counter saturates at its maximum if TIMEOUT=0; counting is irrelevant in that case.
  - Addresses pass through unmodified; alignment is the LSU's job.

Test Plan:
1. Single fetch:
   - Stimulus: ifu_req_valid=1, ifu_addr=0x80000000; mem_req_ready=1 immediately; mem_resp_valid 2 cycles later with mem_rdata=0x00000413.
   - Required: ifu_req_ready=1 in the request cycle; mem_addr=0x80000000, mem_wen=0, mem_funct3=3'b010 while mem_req_valid=1; ifu_resp_valid one cycle after the response with ifu_rdata=0x00000413; lsu_resp_valid stays 0.
2. Tie after reset:
   - Stimulus: IFU and LSU both valid; lsu_addr=0x80001000, lsu_wen=1, lsu_wdata=0xDEADBEEF, lsu_funct3=3'b010.
   - Required: LSU granted first, with mem_wen=1 and mem_wdata=0xDEADBEEF; IFU granted on the next IDLE; after that, alternation on every tie.
3. Backpressure:
   - Stimulus: hold mem_req_ready=0 for 5 cycles.
   - Required: mem_req_valid=1 with mem_addr stable throughout; busy=1; no resp_valid pulse.
4. Timeout with TIMEOUT=4:
   - Stimulus: load from 0x10000004, mem_resp_valid never asserted.
   - Required: lsu_resp_valid pulses with lsu_rdata=0 on the 5th cycle after WAIT entry; bus_err=1; err_addr=0x10000004.
5. Second timeout:
   - Stimulus: a second timed-out access to 0x20000000.
   - Required: err_addr stays 0x10000004.
6. Reset in WAIT:
   - Stimulus: assert rst in WAIT.
   - Required: busy=0 and all outputs 0 immediately (asynchronous); no response pulse after release; a fetch issued afterwards completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one data-memory port between the fetch unit and the
// load/store path. Round-robin on ties, one outstanding transaction, a
// registered response routed to the owner, and a timeout that turns a
// missing memory response into a bus-error response.
module mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_resp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [2:0]  lsu_funct3,
    output logic        lsu_resp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Last WAIT cycle index at which a missing response is turned into an error.
    localparam bit              TMO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t           state;
    state_t           state_nxt;
    logic             owner_lsu;   // 1 = LSU owns the outstanding transaction
    logic             last_lsu;    // 1 = LSU was granted most recently
    logic [CNT_W-1:0] cnt;
    logic             grant_lsu;
    logic             resp_hit;
    logic             tmo_hit;

    // Arbitration, handshake readies and FSM next-state decode.
    always_comb begin
        state_nxt     = state;
        grant_lsu     = lsu_req_valid && (!ifu_req_valid || !last_lsu);
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        resp_hit      = 1'b0;
        tmo_hit       = 1'b0;
        case (state)
            IDLE: begin
                // Readies are masked during reset so every output reads 0.
                ifu_req_ready = !rst && ifu_req_valid && !grant_lsu;
                lsu_req_ready = !rst && grant_lsu;
                if (ifu_req_ready || lsu_req_ready)
                    state_nxt = REQ;
            end
            REQ: begin
                if (mem_req_ready)
                    state_nxt = WAIT;
            end
            WAIT: begin
                // A response arriving on the timeout cycle takes priority.
                resp_hit = mem_resp_valid;
                tmo_hit  = !mem_resp_valid && TMO_EN && (cnt == CNT_LAST);
                if (resp_hit || tmo_hit)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req_valid = (state == REQ);
    assign busy          = (state != IDLE);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Latch the granted request into the memory-side registers and record ownership.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_funct3 <= '0;
            owner_lsu  <= 1'b0;
            last_lsu   <= 1'b0;
        end else if (lsu_req_ready) begin
            mem_addr   <= lsu_addr;
            mem_wen    <= lsu_wen;
            mem_wdata  <= lsu_wdata;
            mem_funct3 <= lsu_funct3;
            owner_lsu  <= 1'b1;
            last_lsu   <= 1'b1;
        end else if (ifu_req_ready) begin
            mem_addr   <= ifu_addr;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_funct3 <= 3'b010;
            owner_lsu  <= 1'b0;
            last_lsu   <= 1'b0;
        end
    end

    // WAIT-state cycle counter; saturates so a disabled timeout never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state == REQ && mem_req_ready)
            cnt <= '0;
        else if (state == WAIT && !resp_hit && !tmo_hit && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    // Register the response (real or forced) toward its owner as a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            lsu_rdata      <= '0;
        end else begin
            ifu_resp_valid <= (resp_hit || tmo_hit) && !owner_lsu;
            lsu_resp_valid <= (resp_hit || tmo_hit) && owner_lsu;
            if ((resp_hit || tmo_hit) && !owner_lsu)
                ifu_rdata <= resp_hit ? mem_rdata : 32'h0;
            if ((resp_hit || tmo_hit) && owner_lsu)
                lsu_rdata <= resp_hit ? mem_rdata : 32'h0;
        end
    end

    // Sticky error flag; only the first timed-out address is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err  <= 1'b0;
            err_addr <= '0;
        end else if (tmo_hit) begin
            bus_err <= 1'b1;
            if (!bus_err)
                err_addr <= mem_addr;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [2:0]  lsu_funct3;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;
    logic        busy, bus_err;
    logic [31:0] err_addr;

    int checks   = 0;
    int failures = 0;

    // Reference model state (transaction level)
    bit          m_last_lsu;
    logic [31:0] m_ifu_rd, m_lsu_rd, m_err_addr;
    bit          m_err;

    mem_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_funct3(lsu_funct3),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last_lsu = 1'b0;
        m_ifu_rd   = '0;
        m_lsu_rd   = '0;
        m_err      = 1'b0;
        m_err_addr = '0;
    endtask

    task automatic check_all_zero(input string nm);
        checks++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid,
             mem_wen, busy, bus_err, mem_funct3} !== 11'b0) begin
            failures++;
            $display("FAIL %s ctrl: got %b want 0", nm,
                     {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_req_valid,
                      mem_wen, busy, bus_err, mem_funct3});
        end
        checks++;
        if ({ifu_rdata, lsu_rdata, mem_addr, mem_wdata, err_addr} !== 160'b0) begin
            failures++;
            $display("FAIL %s data: got %h %h %h %h %h want all 0", nm,
                     ifu_rdata, lsu_rdata, mem_addr, mem_wdata, err_addr);
        end
    endtask

    // One full transaction. Starts in an IDLE cycle (possibly the previous
    // response pulse cycle) and ends in the cycle carrying the response pulse.
    task automatic do_txn(input bit iv, input bit lv, input logic [31:0] ia, input logic [31:0] la,
                          input logic [31:0] wd, input bit wen, input logic [2:0] f3,
                          input int bp, input int dly, input logic [31:0] rd);
        bit          exp_lsu, tmo;
        logic [31:0] ea, ew, erd;
        bit          ewen;
        logic [2:0]  ef;
        exp_lsu = lv && (!iv || !m_last_lsu);
        ea   = exp_lsu ? la  : ia;
        ewen = exp_lsu ? wen : 1'b0;
        ew   = exp_lsu ? wd  : 32'h0;
        ef   = exp_lsu ? f3  : 3'b010;

        ifu_req_valid = iv; lsu_req_valid = lv;
        ifu_addr = ia; lsu_addr = la; lsu_wdata = wd; lsu_wen = wen; lsu_funct3 = f3;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        checks++;
        if ({busy, ifu_req_ready, lsu_req_ready} !== {1'b0, iv && !exp_lsu, exp_lsu}) begin
            failures++;
            $display("FAIL grant: got busy/ifu_rdy/lsu_rdy=%b want %b",
                     {busy, ifu_req_ready, lsu_req_ready}, {1'b0, iv && !exp_lsu, exp_lsu});
        end
        tick();
        m_last_lsu = exp_lsu;

        // Requesters withdraw and scramble their inputs; the transaction must not care.
        ifu_req_valid = $urandom_range(0, 1); lsu_req_valid = $urandom_range(0, 1);
        ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wen = $urandom_range(0, 1);
        for (int i = 0; i <= bp; i++) begin
            mem_req_ready  = (i == bp);
            mem_resp_valid = $urandom_range(0, 1);
            mem_rdata      = $urandom;
            #1;
            checks++;
            if ({mem_req_valid, busy, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 6'b110000) begin
                failures++;
                $display("FAIL req_phase: got vld/busy/rdy/rdy/resp/resp=%b want 110000",
                         {mem_req_valid, busy, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid});
            end
            checks++;
            if ({mem_addr, mem_wen, mem_wdata, mem_funct3} !== {ea, ewen, ew, ef}) begin
                failures++;
                $display("FAIL req_fields: got addr=%h wen=%b wdata=%h f3=%b want addr=%h wen=%b wdata=%h f3=%b",
                         mem_addr, mem_wen, mem_wdata, mem_funct3, ea, ewen, ew, ef);
            end
            tick();
        end
        mem_req_ready = 1'b0;
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        tmo = 1'b1;
        for (int w = 0; w < TMO; w++) begin
            mem_resp_valid = (w == dly);
            mem_rdata      = (w == dly) ? rd : $urandom;
            #1;
            checks++;
            if ({mem_req_valid, busy, ifu_resp_valid, lsu_resp_valid} !== 4'b0100) begin
                failures++;
                $display("FAIL wait_phase: got vld/busy/resp/resp=%b want 0100",
                         {mem_req_valid, busy, ifu_resp_valid, lsu_resp_valid});
            end
            tick();
            if (w == dly) begin
                tmo = 1'b0;
                break;
            end
        end
        mem_resp_valid = 1'b0;

        erd = tmo ? 32'h0 : rd;
        if (exp_lsu) m_lsu_rd = erd; else m_ifu_rd = erd;
        if (tmo) begin
            if (!m_err) m_err_addr = ea;
            m_err = 1'b1;
        end
        checks++;
        if ({busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== {2'b00, !exp_lsu, exp_lsu}) begin
            failures++;
            $display("FAIL resp_pulse: got busy/vld/ifu/lsu=%b want %b",
                     {busy, mem_req_valid, ifu_resp_valid, lsu_resp_valid}, {2'b00, !exp_lsu, exp_lsu});
        end
        checks++;
        if ({ifu_rdata, lsu_rdata} !== {m_ifu_rd, m_lsu_rd}) begin
            failures++;
            $display("FAIL resp_data: got ifu=%h lsu=%h want ifu=%h lsu=%h",
                     ifu_rdata, lsu_rdata, m_ifu_rd, m_lsu_rd);
        end
        checks++;
        if ({bus_err, err_addr} !== {m_err, m_err_addr}) begin
            failures++;
            $display("FAIL err_state: got bus_err=%b err_addr=%h want %b %h",
                     bus_err, err_addr, m_err, m_err_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #3;
        check_all_zero("reset_held");
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset_released");
        tick();
    endtask

    task automatic test_single_fetch();
        do_txn(1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 3'b000, 0, 0, 32'h0000_0413);
        checks++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {2'b10, 32'h0000_0413}) begin
            failures++;
            $display("FAIL single_fetch: got ifu=%b lsu=%b rdata=%h want 1 0 00000413",
                     ifu_resp_valid, lsu_resp_valid, ifu_rdata);
        end
        tick();
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_tie();
        apply_reset();
        do_txn(1'b1, 1'b1, 32'h8000_0004, 32'h8000_1000, 32'hDEAD_BEEF, 1'b1, 3'b010, 0, 1, 32'h0);
        checks++;
        if ({lsu_resp_valid, ifu_resp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL tie_first_lsu: got lsu/ifu=%b want 10", {lsu_resp_valid, ifu_resp_valid});
        end
        // Back-to-back: next request issued in the response-pulse cycle.
        do_txn(1'b1, 1'b1, 32'h8000_0008, 32'h8000_1004, 32'h1234_5678, 1'b0, 3'b100, 0, 0, 32'hCAFE_0001);
        checks++;
        if ({lsu_resp_valid, ifu_resp_valid} !== 2'b01) begin
            failures++;
            $display("FAIL tie_second_ifu: got lsu/ifu=%b want 01", {lsu_resp_valid, ifu_resp_valid});
        end
        for (int k = 0; k < 4; k++)
            do_txn(1'b1, 1'b1, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   0, 0, $urandom);
        tick();
    endtask

    task automatic test_backpressure();
        do_txn(1'b0, 1'b1, 32'h0, 32'h4000_0010, 32'h5555_AAAA, 1'b1, 3'b001, 5, 2, 32'h0);
        tick();
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 1'b1, 32'h0, 32'h1000_0004, 32'h0, 1'b0, 3'b010, 0, 99, 32'hFFFF_FFFF);
        checks++;
        if ({lsu_resp_valid, lsu_rdata, bus_err, err_addr} !== {1'b1, 32'h0, 1'b1, 32'h1000_0004}) begin
            failures++;
            $display("FAIL timeout: got resp=%b rdata=%h bus_err=%b err_addr=%h want 1 0 1 10000004",
                     lsu_resp_valid, lsu_rdata, bus_err, err_addr);
        end
        tick();
    endtask

    task automatic test_second_timeout();
        do_txn(1'b0, 1'b1, 32'h0, 32'h2000_0000, 32'h0, 1'b0, 3'b010, 1, 99, 32'h0);
        checks++;
        if ({bus_err, err_addr} !== {1'b1, 32'h1000_0004}) begin
            failures++;
            $display("FAIL second_timeout: got bus_err=%b err_addr=%h want 1 10000004", bus_err, err_addr);
        end
        // Response on the timeout cycle wins: no error change, real data returned.
        do_txn(1'b1, 1'b0, 32'h3000_0000, 32'h0, 32'h0, 1'b0, 3'b010, 0, TMO - 1, 32'h0BAD_F00D);
        checks++;
        if ({ifu_resp_valid, ifu_rdata, err_addr} !== {1'b1, 32'h0BAD_F00D, 32'h1000_0004}) begin
            failures++;
            $display("FAIL edge_response: got resp=%b rdata=%h err_addr=%h want 1 0badf00d 10000004",
                     ifu_resp_valid, ifu_rdata, err_addr);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        #1;
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_all_zero("reset_in_wait");
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1; mem_rdata = $urandom;
            #1;
            checks++;
            if ({busy, ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== 35'b0) begin
                failures++;
                $display("FAIL post_reset_idle: got busy/ifu/lsu=%b ifu_rdata=%h want 000 0",
                         {busy, ifu_resp_valid, lsu_resp_valid}, ifu_rdata);
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        do_txn(1'b1, 1'b0, 32'h8000_0200, 32'h0, 32'h0, 1'b0, 3'b000, 0, 1, 32'h1357_9BDF);
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            bit iv, lv;
            iv = $urandom_range(0, 1);
            lv = $urandom_range(0, 1);
            if (!iv && !lv) lv = 1'b1;
            do_txn(iv, lv, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 3), $urandom_range(0, TMO + 1), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                tick();
                mem_resp_valid = 1'b1; mem_rdata = $urandom;
                #1;
                checks++;
                if ({busy, ifu_resp_valid, lsu_resp_valid, ifu_rdata, lsu_rdata} !== {3'b000, m_ifu_rd, m_lsu_rd}) begin
                    failures++;
                    $display("FAIL idle_gap: got busy/ifu/lsu=%b rd=%h/%h want 000 %h/%h",
                             {busy, ifu_resp_valid, lsu_resp_valid}, ifu_rdata, lsu_rdata, m_ifu_rd, m_lsu_rd);
                end
                tick();
                mem_resp_valid = 1'b0;
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_funct3 = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        model_reset();
        test_reset();
        test_single_fetch();
        test_tie();
        test_backpressure();
        test_timeout();
        test_second_timeout();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
